// File: rtl/lsu_mem_if_if.sv
// Bus bundles for the load/store unit.
//   lsu_core_if : core-side request/response port (master = core, slave = LSU)
//   lsu_bus_if  : data-memory req/gnt/rvalid port (master = LSU, slave = memory)
interface lsu_core_if #(
    parameter int AWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AWIDTH-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_bus_if #(
    parameter int AWIDTH = 32
);
    logic              mem_req;
    logic              mem_gnt;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit between the core data port and data memory.
// One transaction in flight; alignment check, lane steering, load extension.
// Optional build macro LSU_TIMEOUT_EN: bounds the REQ and WAIT states to
// TIMEOUT_CYCLES cycles each and returns resp_err on expiry.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new request (req_ready=1)
// REQ    | mem_req asserted, address/be/wdata held until mem_gnt
// WAIT   | granted, waiting for mem_rvalid
// RESP   | resp_valid pulse for one cycle, then back to IDLE
module lsu_mem_if #(
    parameter int AWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_core_if.slave   core,
    lsu_bus_if.master   mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        req_bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [31:0] rdata_shift;
    logic [31:0] load_ext;

    logic        resp_set;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        tmo_hit;

    // Parameter sanity: the word address needs two dropped bits and the timer at least one cycle.
    if (AWIDTH < 3 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("lsu_mem_if: AWIDTH must be >= 3 and TIMEOUT_CYCLES >= 1");
    end

    assign core.req_ready = (state_q == S_IDLE);

    // Alignment check and lane steering of the incoming request.
    always_comb begin
        req_bad = 1'b0;
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        case (core.req_size)
            2'd0: begin
                be_d    = 4'b0001 << core.req_addr[1:0];
                wdata_d = {4{core.req_wdata[7:0]}};
            end
            2'd1: begin
                req_bad = core.req_addr[0];
                be_d    = core.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{core.req_wdata[15:0]}};
            end
            2'd2: begin
                req_bad = |core.req_addr[1:0];
                be_d    = 4'b1111;
                wdata_d = core.req_wdata;
            end
            default: begin
                req_bad = 1'b1;
            end
        endcase
    end

    // Right-align the addressed lane of the read word and extend it.
    always_comb begin
        rdata_shift = mem.mem_rdata >> {lo_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'h0, rdata_shift[7:0]}
                                      : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1:    load_ext = uns_q ? {16'h0, rdata_shift[15:0]}
                                      : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Per-state down-counter, reloaded whenever REQ or WAIT is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state_d == S_REQ  && state_q != S_REQ) ||
                     (state_d == S_WAIT && state_q != S_WAIT)) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the response values captured on entry to RESP.
    always_comb begin
        state_d  = state_q;
        resp_set = 1'b0;
        err_d    = 1'b0;
        rdata_d  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (core.req_valid) begin
                    if (req_bad) begin
                        state_d  = S_RESP;
                        resp_set = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A grant-cycle mem_rvalid is not expected and is deliberately not looked at here.
                if (mem.mem_gnt) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    state_d  = S_RESP;
                    resp_set = 1'b1;
                    err_d    = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d  = S_RESP;
                    resp_set = 1'b1;
                    rdata_d  = mem.mem_we ? 32'h0 : load_ext;
                end else if (tmo_hit) begin
                    state_d  = S_RESP;
                    resp_set = 1'b1;
                    err_d    = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered memory-side request and core-side response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req     <= 1'b0;
            mem.mem_addr    <= '0;
            mem.mem_we      <= 1'b0;
            mem.mem_be      <= 4'b0000;
            mem.mem_wdata   <= 32'h0;
            core.resp_valid <= 1'b0;
            core.resp_rdata <= 32'h0;
            core.resp_err   <= 1'b0;
            lo_q            <= 2'b00;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
        end else begin
            mem.mem_req     <= (state_d == S_REQ);
            core.resp_valid <= resp_set;
            if (resp_set) begin
                core.resp_rdata <= rdata_d;
                core.resp_err   <= err_d;
            end
            if (state_q == S_IDLE && core.req_valid && !req_bad) begin
                mem.mem_addr  <= {core.req_addr[AWIDTH-1:2], 2'b00};
                mem.mem_we    <= core.req_we;
                mem.mem_be    <= be_d;
                mem.mem_wdata <= core.req_we ? wdata_d : 32'h0;
                lo_q          <= core.req_addr[1:0];
                size_q        <= core.req_size;
                uns_q         <= core.req_unsigned;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a small word memory model.
module tb_lsu_mem_if;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_core_if #(.AWIDTH(32)) core_bus ();
    lsu_bus_if  #(.AWIDTH(32)) mem_bus ();

    lsu_mem_if #(.AWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_bus),
        .mem   (mem_bus)
    );

    int errors = 0;
    int checks = 0;

    // memory responder controls and storage
    int          gnt_delay = 0;
    int          rv_delay  = 1;
    bit          force_rv  = 1'b0;
    logic [31:0] mem_arr [0:15];

    // monitor state
    int          cyc = 0;
    int          req_cycles = 0;
    int          resp_cnt = 0;
    int          unstable = 0;
    int          last_resp_cyc = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_we = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [3:0]  prev_be = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_bus.mem_req) begin
            req_cycles <= req_cycles + 1;
            cap_addr   <= mem_bus.mem_addr;
            cap_be     <= mem_bus.mem_be;
            cap_we     <= mem_bus.mem_we;
            cap_wdata  <= mem_bus.mem_wdata;
            if (prev_req && (mem_bus.mem_addr !== prev_addr || mem_bus.mem_be !== prev_be))
                unstable <= unstable + 1;
        end
        prev_req  <= mem_bus.mem_req;
        prev_addr <= mem_bus.mem_addr;
        prev_be   <= mem_bus.mem_be;
        if (core_bus.resp_valid) begin
            resp_cnt      <= resp_cnt + 1;
            last_resp_cyc <= cyc;
        end
    end

    // memory model: grant after gnt_delay cycles of mem_req, data rv_delay cycles later
    initial begin
        bit          pend;
        int          wcnt;
        int          rvcnt;
        logic [31:0] pend_data;
        logic [3:0]  idx;
        pend = 1'b0; wcnt = 0; rvcnt = 0; pend_data = '0;
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_gnt = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                wcnt = 0;
            end else if (force_rv) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata = 32'hDEADBEEF;
                force_rv = 1'b0;
            end else if (pend) begin
                if (rvcnt == 0) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata = pend_data;
                    pend = 1'b0;
                end else begin
                    rvcnt--;
                end
            end else if (mem_bus.mem_req) begin
                if (wcnt < gnt_delay) begin
                    wcnt++;
                end else begin
                    mem_bus.mem_gnt = 1'b1;
                    wcnt = 0;
                    idx = mem_bus.mem_addr[5:2];
                    if (mem_bus.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_bus.mem_be[b]) mem_arr[idx][8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
                    end
                    pend_data = mem_arr[idx];
                    pend = 1'b1;
                    rvcnt = rv_delay - 1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // issue one request and wait (bounded) for its response
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int rdy_seen);
        int guard;
        lat = 0; rdy_seen = 0; guard = 0;
        @(negedge clk);
        core_bus.req_we = we;
        core_bus.req_size = size;
        core_bus.req_unsigned = uns;
        core_bus.req_addr = addr;
        core_bus.req_wdata = wdata;
        core_bus.req_valid = 1'b1;
        while (!core_bus.req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        core_bus.req_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (core_bus.resp_valid) break;
            if (core_bus.req_ready) rdy_seen++;
        end
        checks++;
        if (!core_bus.resp_valid) begin
            errors++;
            $display("FAIL resp_wait: no resp_valid after %0d cycles (addr %h)", lat, addr);
        end
        rdata = core_bus.resp_rdata;
        err = core_bus.resp_err;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (core_bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", core_bus.req_ready); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_addr !== 32'h0 || mem_bus.mem_be !== 4'h0 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_mem_bus got addr=%h be=%b we=%b wdata=%h exp all 0", mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_we, mem_bus.mem_wdata); end
        checks++; if (core_bus.resp_valid !== 1'b0 || core_bus.resp_err !== 1'b0 || core_bus.resp_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_resp got v=%b e=%b d=%h exp all 0", core_bus.resp_valid, core_bus.resp_err, core_bus.resp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_d;
        logic [3:0]  exp_be;
    } load_vec_t;

    task automatic test_loads();
        load_vec_t   v [5];
        logic [31:0] rd;
        logic        er;
        int          lat, rdy;
        v[0] = '{32'h101, 2'd0, 1'b0, 32'hFFFFFFAA, 4'b0010};
        v[1] = '{32'h101, 2'd0, 1'b1, 32'h000000AA, 4'b0010};
        v[2] = '{32'h102, 2'd1, 1'b0, 32'hFFFF8899, 4'b1100};
        v[3] = '{32'h102, 2'd1, 1'b1, 32'h00008899, 4'b1100};
        v[4] = '{32'h100, 2'd2, 1'b0, 32'h8899AABB, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, v[i].size, v[i].uns, v[i].addr, 32'hFFFFFFFF, rd, er, lat, rdy);
            checks++; if (rd !== v[i].exp_d) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, v[i].exp_d); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL load%0d_err got=%b exp=0", i, er); end
            checks++; if (cap_be !== v[i].exp_be || cap_addr !== 32'h100) begin
                errors++; $display("FAIL load%0d_bus got be=%b addr=%h exp be=%b addr=00000100", i, cap_be, cap_addr, v[i].exp_be); end
            checks++; if (cap_we !== 1'b0 || cap_wdata !== 32'h0) begin
                errors++; $display("FAIL load%0d_wdata got we=%b wdata=%h exp we=0 wdata=0", i, cap_we, cap_wdata); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL load%0d_latency got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd;
        logic        er;
        int          lat, rdy;
        do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000012, rd, er, lat, rdy);
        checks++; if (cap_we !== 1'b1 || cap_be !== 4'b1000 || cap_wdata !== 32'h12121212) begin
            errors++; $display("FAIL sb_bus got we=%b be=%b wdata=%h exp we=1 be=1000 wdata=12121212", cap_we, cap_be, cap_wdata); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp got d=%h e=%b exp d=0 e=0", rd, er); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, rdy);
        checks++; if (rd !== 32'h1299AABB) begin errors++; $display("FAIL lw_after_sb got=%h exp=1299aabb", rd); end
        do_req(1'b1, 2'd1, 1'b0, 32'h100, 32'h5555BEEF, rd, er, lat, rdy);
        checks++; if (cap_be !== 4'b0011 || cap_wdata !== 32'hBEEFBEEF) begin
            errors++; $display("FAIL sh_bus got be=%b wdata=%h exp be=0011 wdata=beefbeef", cap_be, cap_wdata); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, rdy);
        checks++; if (rd !== 32'h1299BEEF) begin errors++; $display("FAIL lw_after_sh got=%h exp=1299beef", rd); end
    endtask

    task automatic test_misaligned();
        logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz_t [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ad_t [3] = '{32'h102, 32'h101, 32'h100};
        logic [31:0] rd;
        logic        er;
        int          lat, rdy, r0;
        for (int i = 0; i < 3; i++) begin
            r0 = req_cycles;
            do_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hA5A5A5A5, rd, er, lat, rdy);
            checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL bad%0d_resp got e=%b d=%h exp e=1 d=0", i, er, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL bad%0d_latency got=%0d exp=1", i, lat); end
            checks++; if (req_cycles !== r0) begin errors++; $display("FAIL bad%0d_no_mem_req got=%0d req cycles exp=0", i, req_cycles - r0); end
        end
    endtask

    task automatic test_delayed();
        logic [31:0] rd;
        logic        er;
        int          lat, rdy, r0, p0, u0;
        gnt_delay = 3; rv_delay = 2;
        r0 = req_cycles; p0 = resp_cnt; u0 = unstable;
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, er, lat, rdy);
        @(negedge clk);
        checks++; if (core_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL dly_pulse_width resp_valid still %b exp 0", core_bus.resp_valid); end
        #1;
        checks++; if (rd !== 32'h00001299 || er !== 1'b0) begin errors++; $display("FAIL dly_rdata got=%h e=%b exp=00001299 e=0", rd, er); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL dly_latency got=%0d exp=7", lat); end
        checks++; if (req_cycles - r0 !== 4) begin errors++; $display("FAIL dly_req_cycles got=%0d exp=4", req_cycles - r0); end
        checks++; if (unstable !== u0 || cap_be !== 4'b1100 || cap_addr !== 32'h100) begin
            errors++; $display("FAIL dly_stable got changes=%0d be=%b addr=%h exp 0 1100 00000100", unstable - u0, cap_be, cap_addr); end
        checks++; if (resp_cnt - p0 !== 1) begin errors++; $display("FAIL dly_resp_count got=%0d exp=1", resp_cnt - p0); end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL dly_ready_busy got=%0d ready cycles exp=0", rdy); end
        gnt_delay = 0; rv_delay = 1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat, rdy, c1;
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, er, lat, rdy);
        c1 = last_resp_cyc;
        checks++; if (rd !== 32'h00000012) begin errors++; $display("FAIL b2b_first got=%h exp=00000012", rd); end
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, rd, er, lat, rdy);
        checks++; if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL b2b_second got=%h exp=ffffffef", rd); end
        checks++; if (last_resp_cyc - c1 !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", last_resp_cyc - c1); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        er;
        int          lat, rdy, r0, p0;
        gnt_delay = 20;
        r0 = req_cycles;
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, rdy);
`ifdef LSU_TIMEOUT_EN
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL tmo_resp got e=%b d=%h exp e=1 d=0", er, rd); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL tmo_latency got=%0d exp=9", lat); end
        checks++; if (req_cycles - r0 !== 8 || mem_bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL tmo_mem_req got cycles=%0d req=%b exp 8 0", req_cycles - r0, mem_bus.mem_req); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'h1299BEEF) begin errors++; $display("FAIL slow_gnt_resp got e=%b d=%h exp e=0 d=1299beef", er, rd); end
        checks++; if (lat !== 23) begin errors++; $display("FAIL slow_gnt_latency got=%0d exp=23", lat); end
        checks++; if (req_cycles - r0 !== 21) begin errors++; $display("FAIL slow_gnt_req_cycles got=%0d exp=21", req_cycles - r0); end
`endif
        p0 = resp_cnt;
        force_rv = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (resp_cnt !== p0) begin errors++; $display("FAIL late_rvalid_ignored got=%0d responses exp=0", resp_cnt - p0); end
        gnt_delay = 0;
    endtask

    task automatic test_reset_abort();
        int p0;
        logic [31:0] rd;
        logic        er;
        int          lat, rdy;
        rv_delay = 6;
        @(negedge clk);
        core_bus.req_we = 1'b0; core_bus.req_size = 2'd2; core_bus.req_unsigned = 1'b0;
        core_bus.req_addr = 32'h100; core_bus.req_wdata = 32'h0; core_bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        core_bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (core_bus.req_ready !== 1'b0 || mem_bus.mem_addr !== 32'h100) begin
            errors++; $display("FAIL abort_pre_wait got ready=%b addr=%h exp 0 00000100", core_bus.req_ready, mem_bus.mem_addr); end
        p0 = resp_cnt;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 32'h0 || mem_bus.mem_be !== 4'h0 ||
                      mem_bus.mem_we !== 1'b0 || mem_bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL abort_mem_outputs got req=%b addr=%h be=%b we=%b wd=%h exp all 0",
                               mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_we, mem_bus.mem_wdata); end
        checks++; if (core_bus.resp_valid !== 1'b0 || core_bus.resp_rdata !== 32'h0 || core_bus.resp_err !== 1'b0 || core_bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_core_outputs got v=%b d=%h e=%b rdy=%b exp 0 0 0 1",
                               core_bus.resp_valid, core_bus.resp_rdata, core_bus.resp_err, core_bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        rv_delay = 1;
        force_rv = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (resp_cnt !== p0 || core_bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_stale_rvalid got responses=%0d ready=%b exp 0 1", resp_cnt - p0, core_bus.req_ready); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, rdy);
        checks++; if (rd !== 32'h1299BEEF || er !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL abort_recover got d=%h e=%b lat=%0d exp 1299beef 0 3", rd, er, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
        mem_arr[0] = 32'h8899AABB;
        core_bus.req_valid = 1'b0;
        core_bus.req_we = 1'b0;
        core_bus.req_size = 2'd0;
        core_bus.req_unsigned = 1'b0;
        core_bus.req_addr = 32'h0;
        core_bus.req_wdata = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_delayed();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
